// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalise / round / pack back end for the FP add/sub datapath.
// Stages: S1 leading-zero normalise, S2 IEEE rounding, S3 exception handling and pack.
module fp_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W+4:0]         in_mant,
    input  logic [1:0]               in_rm,
    input  logic                     in_inf,
    input  logic                     in_nan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_r,
    output logic [2:0]               out_flags
);

    localparam int MW  = MAN_W + 5;
    localparam int LZW = $clog2(MW) + 1;
    localparam int EW  = EXP_W + 2;
    localparam int RW  = 1 + EXP_W + MAN_W;
    localparam logic signed [EW-1:0] E_TOP = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP} rm_e;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: normalise ----------------
    logic [LZW-1:0]        lzc;
    logic [LZW-1:0]        sh;
    logic [MW-1:0]         n1_mant;
    logic signed [EW-1:0]  n1_exp;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (in_mant[i]) lzc = LZW'(MW - 1 - i);
        end
        sh      = lzc - LZW'(1);
        n1_mant = in_mant << sh;
        n1_exp  = EW'(in_exp) - EW'(sh);
        if (in_mant[MW-1]) begin
            // Carry out of the adder: drop one bit, keeping it alive in sticky.
            n1_mant = {1'b0, in_mant[MW-1:2], |in_mant[1:0]};
            n1_exp  = EW'(in_exp) + EW'(1);
        end
    end

    logic                 s1_valid, s1_sign, s1_inf, s1_nan, s1_zero;
    rm_e                  s1_rm;
    logic signed [EW-1:0] s1_exp;
    logic [MW-1:0]        s1_mant;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_nan   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_rm    <= RM_RNE;
            s1_exp   <= '0;
            s1_mant  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sign  <= in_sign;
            s1_inf   <= in_inf;
            s1_nan   <= in_nan;
            s1_zero  <= (in_mant == '0);
            s1_rm    <= rm_e'(in_rm);
            s1_exp   <= n1_exp;
            s1_mant  <= n1_mant;
        end
    end

    // ---------------- S2: round ----------------
    logic                 lsb, g, rs, inc, n2_nx;
    logic [MAN_W+1:0]     sum;
    logic [MAN_W-1:0]     n2_frac;
    logic signed [EW-1:0] n2_exp;

    always_comb begin
        lsb = s1_mant[3];
        g   = s1_mant[2];
        rs  = s1_mant[1] | s1_mant[0];
        unique case (s1_rm)
            RM_RNE:  inc = g & (rs | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1_sign & (g | rs);
            RM_RUP:  inc = ~s1_sign & (g | rs);
            default: inc = 1'b0;
        endcase
        n2_nx   = g | rs;
        sum     = {1'b0, s1_mant[MW-2:3]} + (MAN_W+2)'(inc);
        n2_frac = sum[MAN_W+1] ? '0 : sum[MAN_W-1:0];
        n2_exp  = s1_exp + EW'(sum[MAN_W+1]);
    end

    logic                 s2_valid, s2_sign, s2_inf, s2_nan, s2_zero, s2_nx;
    rm_e                  s2_rm;
    logic signed [EW-1:0] s2_exp;
    logic [MAN_W-1:0]     s2_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_inf   <= 1'b0;
            s2_nan   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_nx    <= 1'b0;
            s2_rm    <= RM_RNE;
            s2_exp   <= '0;
            s2_frac  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_inf   <= s1_inf;
            s2_nan   <= s1_nan;
            s2_zero  <= s1_zero;
            s2_nx    <= n2_nx;
            s2_rm    <= s1_rm;
            s2_exp   <= n2_exp;
            s2_frac  <= n2_frac;
        end
    end

    // ---------------- S3: exceptions and pack ----------------
    logic [RW-1:0] n3_r;
    logic [2:0]    n3_flags;
    logic          to_inf;

    always_comb begin
        to_inf   = (s2_rm == RM_RNE) || (s2_rm == RM_RUP && !s2_sign) ||
                   (s2_rm == RM_RDN && s2_sign);
        n3_r     = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        n3_flags = {2'b00, s2_nx};
        if (s2_nan) begin
            n3_r     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            n3_flags = 3'b000;
        end else if (s2_inf) begin
            n3_r     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            n3_flags = 3'b000;
        end else if (s2_zero) begin
            n3_r     = {s2_rm == RM_RDN, {(EXP_W+MAN_W){1'b0}}};
            n3_flags = 3'b000;
        end else if (s2_exp >= E_TOP) begin
            n3_r     = to_inf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                              : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            n3_flags = 3'b101;
        end else if (s2_exp[EW-1] || s2_exp == '0) begin
            n3_r     = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            n3_flags = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_flags <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_r     <= n3_r;
            out_flags <= n3_flags;
        end
    end

endmodule
